// File: rtl/conv_layer_pkg.sv
// rtl/conv_layer_pkg.sv - shared conv-layer state codes and default geometry
package conv_layer_pkg;

  localparam int CONV_DATA_WIDTH = 32;
  localparam int CONV_PORT_NUM   = 6;
  localparam int CONV_ROW_NUM    = 6;
  localparam int CONV_ADDR_WIDTH = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3
  } conv_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_row_serializer.sv
// rtl/conv_row_serializer.sv - row holding buffer with indexed word output
module conv_row_serializer
  import conv_layer_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int PORT_NUM   = CONV_PORT_NUM,
  parameter int IDX_W      = clog2_min1(CONV_PORT_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_load,
  input  logic [PORT_NUM*DATA_WIDTH-1:0] i_row,
  input  logic [IDX_W-1:0]               i_index,
  output logic [DATA_WIDTH-1:0]          o_word
);

  logic [DATA_WIDTH-1:0] r_words [PORT_NUM];

  // word 0 sits in the MSBs of the incoming row
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PORT_NUM; k++) r_words[k] <= '0;
    end else if (i_load) begin
      for (int k = 0; k < PORT_NUM; k++)
        r_words[k] <= i_row[(PORT_NUM-1-k)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_word = r_words[i_index];

endmodule

// File: rtl/conv_layer_output_interface.sv
// rtl/conv_layer_output_interface.sv - serialises accepted rows into sequential RAM writes
module conv_layer_output_interface
  import conv_layer_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int PORT_NUM   = CONV_PORT_NUM,
  parameter int ROW_NUM    = CONV_ROW_NUM,
  parameter int ADDR_WIDTH = CONV_ADDR_WIDTH,
  parameter int BASE_ADDR  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           in_valid,
  input  logic [PORT_NUM*DATA_WIDTH-1:0] in_result_port,
  output logic                           in_ready,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [DATA_WIDTH-1:0]          ram_data,
  output logic                           ram_we,
  output logic                           done,
  output logic [2:0]                     current_state
);

  localparam int IDX_W = clog2_min1(PORT_NUM);
  localparam int ROW_W = clog2_min1(ROW_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PORT_NUM - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROW_NUM - 1);

  conv_state_t           r_state;
  conv_state_t           w_next_state;
  logic [IDX_W-1:0]      r_index;
  logic [ROW_W-1:0]      r_row;
  logic                  w_in_ready;
  logic                  w_load;
  logic                  w_row_end;
  logic [DATA_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_row_end = (r_index == LAST_IDX);
  assign w_load    = in_valid && w_in_ready;
  assign w_addr    = ADDR_WIDTH'(BASE_ADDR + int'(r_row) * PORT_NUM + int'(r_index));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // the final word of a non-last row opens a one-cycle accept window so rows chain without a gap
  always_comb begin
    w_next_state = ST_IDLE;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE:  w_next_state = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        w_in_ready = 1'b1;
        if (in_valid)     w_next_state = ST_WRITE;
        else if (!enable) w_next_state = ST_IDLE;
        else              w_next_state = ST_WAIT;
      end
      ST_WRITE: begin
        w_in_ready = w_row_end && (r_row != LAST_ROW);
        if (!w_row_end)               w_next_state = ST_WRITE;
        else if (in_valid && w_in_ready) w_next_state = ST_WRITE;
        else if (r_row == LAST_ROW)   w_next_state = ST_DONE;
        else                          w_next_state = ST_WAIT;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_index  <= '0;
      r_row    <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      done     <= 1'b0;
    end else begin
      ram_we <= (r_state == ST_WRITE);
      done   <= (r_state == ST_DONE);
      case (r_state)
        ST_WAIT: begin
          if (w_load) begin
            r_index <= '0;
          end else if (!enable) begin
            r_row    <= '0;
            ram_addr <= '0;
          end
        end
        ST_WRITE: begin
          ram_addr <= w_addr;
          ram_data <= w_word;
          if (w_row_end) begin
            r_index <= '0;
            if (r_row != LAST_ROW) r_row <= r_row + ROW_W'(1);
          end else begin
            r_index <= r_index + IDX_W'(1);
          end
        end
        ST_DONE: begin
          r_row    <= '0;
          ram_addr <= '0;
        end
        default: ;
      endcase
    end
  end

  conv_row_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PORT_NUM   (PORT_NUM),
    .IDX_W      (IDX_W)
  ) u_serializer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_row   (in_result_port),
    .i_index (r_index),
    .o_word  (w_word)
  );

  assign in_ready      = w_in_ready;
  assign current_state = r_state;

endmodule

// File: tb/tb_conv_layer_output_interface.sv
// tb/tb_conv_layer_output_interface.sv - randomized self-checking bench for conv_layer_output_interface
module tb_conv_layer_output_interface;

  localparam int DW = 32;
  localparam int PN = 6;
  localparam int RN = 6;
  localparam int AW = 6;
  localparam int BASE1 = 20;

  logic clk = 1'b0;
  logic rst, enable, in_valid;
  logic [PN*DW-1:0] in_result_port;

  logic in_ready0, ram_we0, done0, in_ready1, ram_we1, done1;
  logic [AW-1:0] ram_addr0, ram_addr1;
  logic [DW-1:0] ram_data0, ram_data1;
  logic [2:0] state0, state1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  conv_layer_output_interface #(.DATA_WIDTH(DW), .PORT_NUM(PN), .ROW_NUM(RN), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_result_port(in_result_port),
    .in_ready(in_ready0), .ram_addr(ram_addr0), .ram_data(ram_data0), .ram_we(ram_we0),
    .done(done0), .current_state(state0));

  conv_layer_output_interface #(.DATA_WIDTH(DW), .PORT_NUM(PN), .ROW_NUM(RN), .ADDR_WIDTH(AW), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_result_port(in_result_port),
    .in_ready(in_ready1), .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_we(ram_we1),
    .done(done1), .current_state(state1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int q_addr0[$];
  int q_addr1[$];
  int q_cyc0[$];
  logic [DW-1:0] q_data0[$];
  logic [DW-1:0] q_data1[$];
  int done0_cnt = 0;
  int done1_cnt = 0;

  always @(negedge clk) begin
    if (ram_we0) begin q_addr0.push_back(int'(ram_addr0)); q_data0.push_back(ram_data0); q_cyc0.push_back(cyc); end
    if (ram_we1) begin q_addr1.push_back(int'(ram_addr1)); q_data1.push_back(ram_data1); end
    if (done0) done0_cnt++;
    if (done1) done1_cnt++;
  end

  // reference: the r-th row of a frame lands at BASE + r*PN + k, word 0 first
  int e_addr0[$];
  int e_addr1[$];
  logic [DW-1:0] e_data[$];
  int frame_row = 0;

  task automatic model_row(input logic [PN*DW-1:0] row);
    for (int k = 0; k < PN; k++) begin
      e_addr0.push_back(frame_row * PN + k);
      e_addr1.push_back(BASE1 + frame_row * PN + k);
      e_data.push_back(row[(PN-1-k)*DW +: DW]);
    end
    frame_row = (frame_row + 1) % RN;
  endtask

  task automatic clear_q();
    q_addr0.delete(); q_addr1.delete(); q_cyc0.delete(); q_data0.delete(); q_data1.delete();
    e_addr0.delete(); e_addr1.delete(); e_data.delete();
    done0_cnt = 0; done1_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_result_port = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
    frame_row = 0;
  endtask

  task automatic rand_row(output logic [PN*DW-1:0] row);
    for (int k = 0; k < PN; k++) row[(PN-1-k)*DW +: DW] = $urandom;
  endtask

  // called #1 after a rising edge; returns #1 after the accepting edge
  task automatic send_row(input logic [PN*DW-1:0] row, output int acc_cyc);
    logic acc;
    in_result_port = row;
    in_valid = 1'b1;
    acc_cyc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk); acc = in_ready0;
      @(posedge clk); #1;
      if (acc) begin acc_cyc = cyc; break; end
    end
    in_valid = 1'b0;
    total++;
    if (acc_cyc < 0) begin bad++; $display("FAIL accept_timeout got=none exp=accept"); end
    else model_row(row);
  endtask

  task automatic wait_writes(input int n);
    for (int t = 0; t < 200 && q_addr0.size() < n; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (ram_we0 !== 1'b0)   begin bad++; $display("FAIL reset_we got=%0b exp=0", ram_we0); end
    total++; if (ram_addr0 !== '0)   begin bad++; $display("FAIL reset_addr got=%0d exp=0", ram_addr0); end
    total++; if (ram_data0 !== '0)   begin bad++; $display("FAIL reset_data got=%0h exp=0", ram_data0); end
    total++; if (done0 !== 1'b0)     begin bad++; $display("FAIL reset_done got=%0b exp=0", done0); end
    total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", in_ready0); end
    total++; if (state0 !== 3'd0)    begin bad++; $display("FAIL reset_state got=%0d exp=0", state0); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_row();
    logic [PN*DW-1:0] row;
    int acc;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < PN; k++) row[(PN-1-k)*DW +: DW] = DW'(k + 1);
    send_row(row, acc);
    wait_writes(PN);
    repeat (3) @(negedge clk);
    total++; if (q_addr0.size() !== PN) begin bad++; $display("FAIL single_count got=%0d exp=%0d", q_addr0.size(), PN); end
    for (int k = 0; k < PN && k < q_addr0.size(); k++) begin
      total++; if (q_addr0[k] !== k)          begin bad++; $display("FAIL single_addr[%0d] got=%0d exp=%0d", k, q_addr0[k], k); end
      total++; if (q_data0[k] !== DW'(k + 1)) begin bad++; $display("FAIL single_data[%0d] got=%0h exp=%0h", k, q_data0[k], k + 1); end
      total++; if (q_cyc0[k] !== acc + 1 + k) begin bad++; $display("FAIL single_cycle[%0d] got=%0d exp=%0d", k, q_cyc0[k], acc + 1 + k); end
    end
    total++; if (ram_we0 !== 1'b0) begin bad++; $display("FAIL single_we_after got=%0b exp=0", ram_we0); end
    total++; if (state0 !== 3'd1)  begin bad++; $display("FAIL single_state got=%0d exp=1", state0); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame();
    logic [PN*DW-1:0] row;
    int acc;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < RN; r++) begin
      rand_row(row);
      send_row(row, acc);
      enable = 1'b0;
    end
    for (int t = 0; t < 200 && done0_cnt == 0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    total++; if (q_addr0.size() !== PN*RN) begin bad++; $display("FAIL frame_count got=%0d exp=%0d", q_addr0.size(), PN*RN); end
    for (int i = 0; i < PN*RN && i < q_addr0.size(); i++) begin
      total++; if (q_addr0[i] !== e_addr0[i])   begin bad++; $display("FAIL frame_addr[%0d] got=%0d exp=%0d", i, q_addr0[i], e_addr0[i]); end
      total++; if (q_data0[i] !== e_data[i])    begin bad++; $display("FAIL frame_data[%0d] got=%0h exp=%0h", i, q_data0[i], e_data[i]); end
      total++; if (q_cyc0[i] !== q_cyc0[0] + i) begin bad++; $display("FAIL frame_contig[%0d] got=%0d exp=%0d", i, q_cyc0[i], q_cyc0[0] + i); end
    end
    total++; if (q_addr1.size() !== PN*RN) begin bad++; $display("FAIL base_count got=%0d exp=%0d", q_addr1.size(), PN*RN); end
    for (int i = 0; i < PN*RN && i < q_addr1.size(); i++) begin
      total++; if (q_addr1[i] !== e_addr1[i]) begin bad++; $display("FAIL base_addr[%0d] got=%0d exp=%0d", i, q_addr1[i], e_addr1[i]); end
      total++; if (q_data1[i] !== e_data[i])  begin bad++; $display("FAIL base_data[%0d] got=%0h exp=%0h", i, q_data1[i], e_data[i]); end
    end
    total++; if (done0_cnt !== 1) begin bad++; $display("FAIL frame_done got=%0d exp=1", done0_cnt); end
    total++; if (done1_cnt !== 1) begin bad++; $display("FAIL base_done got=%0d exp=1", done1_cnt); end
    total++; if (state0 !== 3'd0) begin bad++; $display("FAIL frame_state got=%0d exp=0", state0); end
    @(posedge clk); #1;
  endtask

  task automatic test_gapped_rows();
    logic [PN*DW-1:0] row;
    int acc;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      rand_row(row);
      send_row(row, acc);
      wait_writes(PN * (r + 1));
      for (int g = 0; g < 5; g++) begin
        @(negedge clk);
        total++; if (ram_we0 !== 1'b0)   begin bad++; $display("FAIL gap_we r%0d g%0d got=%0b exp=0", r, g, ram_we0); end
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL gap_ready r%0d g%0d got=%0b exp=1", r, g, in_ready0); end
      end
      @(posedge clk); #1;
    end
    total++; if (q_addr0.size() !== 3*PN) begin bad++; $display("FAIL gap_count got=%0d exp=%0d", q_addr0.size(), 3*PN); end
    for (int i = 0; i < 3*PN && i < q_addr0.size(); i++) begin
      total++; if (q_addr0[i] !== e_addr0[i]) begin bad++; $display("FAIL gap_addr[%0d] got=%0d exp=%0d", i, q_addr0[i], e_addr0[i]); end
      total++; if (q_data0[i] !== e_data[i])  begin bad++; $display("FAIL gap_data[%0d] got=%0h exp=%0h", i, q_data0[i], e_data[i]); end
    end
  endtask

  task automatic test_enable_drop();
    logic [PN*DW-1:0] row;
    int acc;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin rand_row(row); send_row(row, acc); end
    wait_writes(2*PN);
    @(posedge clk); #1;
    total++; if (q_addr0.size() !== 2*PN) begin bad++; $display("FAIL drop_pre_count got=%0d exp=%0d", q_addr0.size(), 2*PN); end
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (state0 !== 3'd0) begin bad++; $display("FAIL drop_state got=%0d exp=0", state0); end
    clear_q();
    frame_row = 0;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    rand_row(row);
    send_row(row, acc);
    wait_writes(PN);
    total++; if (q_addr0.size() !== PN) begin bad++; $display("FAIL drop_count got=%0d exp=%0d", q_addr0.size(), PN); end
    for (int i = 0; i < PN && i < q_addr0.size(); i++) begin
      total++; if (q_addr0[i] !== e_addr0[i]) begin bad++; $display("FAIL drop_addr[%0d] got=%0d exp=%0d", i, q_addr0[i], e_addr0[i]); end
      total++; if (q_data0[i] !== e_data[i])  begin bad++; $display("FAIL drop_data[%0d] got=%0h exp=%0h", i, q_data0[i], e_data[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    logic [PN*DW-1:0] row;
    int acc;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    rand_row(row);
    send_row(row, acc);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ram_we0 !== 1'b0)   begin bad++; $display("FAIL rstmid_we got=%0b exp=0", ram_we0); end
    total++; if (ram_addr0 !== '0)   begin bad++; $display("FAIL rstmid_addr got=%0d exp=0", ram_addr0); end
    total++; if (ram_data0 !== '0)   begin bad++; $display("FAIL rstmid_data got=%0h exp=0", ram_data0); end
    total++; if (done0 !== 1'b0)     begin bad++; $display("FAIL rstmid_done got=%0b exp=0", done0); end
    total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%0b exp=0", in_ready0); end
    total++; if (state0 !== 3'd0)    begin bad++; $display("FAIL rstmid_state got=%0d exp=0", state0); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (q_addr0.size() !== 3) begin bad++; $display("FAIL rstmid_count got=%0d exp=3", q_addr0.size()); end
    for (int i = 0; i < 3 && i < q_addr0.size(); i++) begin
      total++; if (q_data0[i] !== e_data[i]) begin bad++; $display("FAIL rstmid_data[%0d] got=%0h exp=%0h", i, q_data0[i], e_data[i]); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_row();
    test_full_frame();
    test_gapped_rows();
    test_enable_drop();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
